// File: rtl/dpd_poly_apply.sv
// dpd_poly_apply: y = x * sum(c_k * mag_k), 4-stage pipeline with shadow/active coefficient banks.
// DPD_SAT_EN: saturate the 20-bit outputs instead of two's-complement wrap.
module dpd_poly_apply (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic signed [19:0] sig_in_i,
  input  logic signed [19:0] sig_in_q,
  input  logic [19:0]        mag_0,
  input  logic [19:0]        mag_1,
  input  logic [19:0]        mag_2,
  input  logic [19:0]        mag_3,
  input  logic [19:0]        mag_4,
  input  logic               coef_we,
  input  logic [3:0]         coef_addr,
  input  logic signed [17:0] coef_data,
  input  logic               coef_swap,
  output logic               out_valid,
  output logic signed [19:0] sig_out_i,
  output logic signed [19:0] sig_out_q
);
  logic [19:0] mag [5];
  logic signed [17:0] sh_re [5], sh_im [5], act_re [5], act_im [5], sh_re_n [5], sh_im_n [5];
  logic signed [37:0] p_re [5], p_im [5];
  logic signed [19:0] x1_i, x1_q, x2_i, x2_q, y_i, y_q;
  logic signed [20:0] g_re, g_im, g_re_n, g_im_n;
  logic signed [40:0] m_ii, m_qq, m_iq, m_qi;
  logic signed [41:0] r_i, r_q;
  logic [2:0] v;
  function automatic logic signed [20:0] rnd19(input logic signed [37:0] p);
    logic signed [37:0] t;
    t = p + 38'sd262144;
    return 21'(t >>> 19);
  endfunction
`ifdef DPD_SAT_EN
  function automatic logic signed [19:0] fit(input logic signed [41:0] r);
    return (r > 42'sd524287) ? 20'sh7ffff : (r < -42'sd524288) ? 20'sh80000 : 20'(r);
  endfunction
`else
  function automatic logic signed [19:0] fit(input logic signed [41:0] r);
    return 20'(r);
  endfunction
`endif
  assign mag = '{mag_0, mag_1, mag_2, mag_3, mag_4};
  // a write in the swap cycle is forwarded straight into the active bank
  always_comb begin
    for (int k = 0; k < 5; k++) begin
      sh_re_n[k] = (coef_we && coef_addr == 4'(k)) ? coef_data : sh_re[k];
      sh_im_n[k] = (coef_we && coef_addr == 4'(k + 8)) ? coef_data : sh_im[k];
    end
  end
  always_comb begin
    g_re_n = '0;
    g_im_n = '0;
    for (int k = 0; k < 5; k++) begin
      g_re_n = g_re_n + rnd19(p_re[k]);
      g_im_n = g_im_n + rnd19(p_im[k]);
    end
  end
  assign r_i = (42'(m_ii) - 42'(m_qq) + 42'sd32768) >>> 16;
  assign r_q = (42'(m_iq) + 42'(m_qi) + 42'sd32768) >>> 16;
  assign y_i = fit(r_i);
  assign y_q = fit(r_q);
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 5; k++) begin
        sh_re[k]  <= (k == 0) ? 18'sd65536 : 18'sd0;
        act_re[k] <= (k == 0) ? 18'sd65536 : 18'sd0;
        sh_im[k]  <= '0;
        act_im[k] <= '0;
        p_re[k]   <= '0;
        p_im[k]   <= '0;
      end
      x1_i      <= '0;
      x1_q      <= '0;
      x2_i      <= '0;
      x2_q      <= '0;
      g_re      <= '0;
      g_im      <= '0;
      m_ii      <= '0;
      m_qq      <= '0;
      m_iq      <= '0;
      m_qi      <= '0;
      v         <= '0;
      out_valid <= 1'b0;
      sig_out_i <= '0;
      sig_out_q <= '0;
    end else begin
      sh_re <= sh_re_n;
      sh_im <= sh_im_n;
      if (coef_swap) begin
        act_re <= sh_re_n;
        act_im <= sh_im_n;
      end
      for (int k = 0; k < 5; k++) begin
        p_re[k] <= 38'(act_re[k]) * 38'($signed({1'b0, mag[k]}));
        p_im[k] <= 38'(act_im[k]) * 38'($signed({1'b0, mag[k]}));
      end
      x1_i      <= sig_in_i;
      x1_q      <= sig_in_q;
      x2_i      <= x1_i;
      x2_q      <= x1_q;
      g_re      <= g_re_n;
      g_im      <= g_im_n;
      m_ii      <= 41'(x2_i) * 41'(g_re);
      m_qq      <= 41'(x2_q) * 41'(g_im);
      m_iq      <= 41'(x2_i) * 41'(g_im);
      m_qi      <= 41'(x2_q) * 41'(g_re);
      v         <= {v[1:0], in_valid};
      out_valid <= v[2];
      sig_out_i <= y_i;
      sig_out_q <= y_q;
    end
  end
endmodule

// File: tb/tb_dpd_poly_apply.sv
// tb_dpd_poly_apply: directed and random checks of dpd_poly_apply against an arithmetic model of the gain and bank rules.
module tb_dpd_poly_apply;
  logic clk = 0, reset = 1, in_valid = 0, coef_we = 0, coef_swap = 0;
  logic [19:0] sig_in_i = 0, sig_in_q = 0;
  logic [19:0] mag [5];
  logic [3:0] coef_addr = 0;
  logic [17:0] coef_data = 0;
  logic out_valid;
  logic [19:0] sig_out_i, sig_out_q;
  int total = 0, bad = 0;
  longint sh_re [5], sh_im [5], ac_re [5], ac_im [5];
  typedef struct {longint v, i, q;} exp_t;
  exp_t pipe [$];
  always #5 clk = ~clk;
  dpd_poly_apply dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .sig_in_i(sig_in_i), .sig_in_q(sig_in_q),
    .mag_0(mag[0]), .mag_1(mag[1]), .mag_2(mag[2]), .mag_3(mag[3]), .mag_4(mag[4]),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_swap(coef_swap),
    .out_valid(out_valid), .sig_out_i(sig_out_i), .sig_out_q(sig_out_q)
  );
  function automatic longint rs(input longint x, input int s);
    return (x + (longint'(1) <<< (s - 1))) >>> s;
  endfunction
  function automatic longint fit(input longint x);
`ifdef DPD_SAT_EN
    return x > 524287 ? 524287 : x < -524288 ? -524288 : x;
`else
    longint w = x & 64'hFFFFF;
    return w > 524287 ? w - 1048576 : w;
`endif
  endfunction
  function automatic exp_t model();
    exp_t e;
    longint gr = 0, gi = 0, xi, xq;
    xi = longint'($signed(sig_in_i));
    xq = longint'($signed(sig_in_q));
    for (int k = 0; k < 5; k++) begin
      gr += rs(ac_re[k] * longint'(mag[k]), 19);
      gi += rs(ac_im[k] * longint'(mag[k]), 19);
    end
    e.v = longint'(in_valid);
    e.i = fit(rs(xi * gr - xq * gi, 16));
    e.q = fit(rs(xi * gi + xq * gr, 16));
    return e;
  endfunction
  task automatic chk(input string tag, input logic signed [63:0] obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    exp_t e;
    if (reset) begin
      pipe.delete();
      repeat (4) pipe.push_back('{0, 0, 0});
      for (int k = 0; k < 5; k++) begin
        sh_re[k] = (k == 0) ? 65536 : 0;
        ac_re[k] = (k == 0) ? 65536 : 0;
        sh_im[k] = 0;
        ac_im[k] = 0;
      end
    end else begin
      pipe.push_back(model());
      if (coef_we && coef_addr < 5) sh_re[coef_addr] = longint'($signed(coef_data));
      else if (coef_we && coef_addr >= 8 && coef_addr <= 12) sh_im[coef_addr - 8] = longint'($signed(coef_data));
      if (coef_swap) begin
        ac_re = sh_re;
        ac_im = sh_im;
      end
    end
    @(posedge clk);
    #1;
    reset = 0;
    coef_we = 0;
    coef_swap = 0;
    e = pipe.pop_front();
    chk("model_valid", {63'b0, out_valid}, e.v);
    chk("model_i", 64'($signed(sig_out_i)), e.i);
    chk("model_q", 64'($signed(sig_out_q)), e.q);
  endtask
  task automatic put(input int xi, input int xq, input int m0, input int m1);
    sig_in_i = 20'(xi);
    sig_in_q = 20'(xq);
    mag[0] = 20'(m0);
    mag[1] = 20'(m1);
    mag[2] = 0;
    mag[3] = 0;
    mag[4] = 0;
    in_valid = 1;
  endtask
  task automatic wr(input int a, input int d, input bit sw);
    coef_we = 1;
    coef_addr = 4'(a);
    coef_data = 18'(d);
    coef_swap = sw;
  endtask
  initial begin
    foreach (mag[k]) mag[k] = 0;
    reset = 1;
    step();
    reset = 1;
    step();
    // identity bank after reset
    put(100000, -50000, 524287, 0);
    for (int k = 1; k < 5; k++) mag[k] = 20'($urandom_range(0, 524287));
    repeat (4) step();
    chk("id_valid", {63'b0, out_valid}, 1);
    chk("id_i", 64'($signed(sig_out_i)), 100000);
    chk("id_q", 64'($signed(sig_out_q)), -50000);
    // shadow write alone is invisible until swapped
    wr(9, 32768, 0);
    put(200000, 0, 524287, 262144);
    step();
    repeat (4) step();
    chk("nowr_i", 64'($signed(sig_out_i)), 200000);
    chk("nowr_q", 64'($signed(sig_out_q)), 0);
    coef_swap = 1;
    step();
    repeat (3) step();
    chk("pre_swap_q", 64'($signed(sig_out_q)), 0);
    step();
    chk("post_swap_i", 64'($signed(sig_out_i)), 200000);
    chk("post_swap_q", 64'($signed(sig_out_q)), 50000);
    // write and swap in the same cycle
    put(300000, 0, 524287, 0);
    wr(0, 32768, 1);
    step();
    repeat (3) step();
    chk("ws_old_i", 64'($signed(sig_out_i)), 300000);
    step();
    chk("ws_new_i", 64'($signed(sig_out_i)), 150000);
    chk("ws_new_q", 64'($signed(sig_out_q)), 0);
    // output range limit
    put(400000, 0, 524287, 0);
    wr(0, 131071, 1);
    step();
    repeat (4) step();
`ifdef DPD_SAT_EN
    chk("sat_i", 64'($signed(sig_out_i)), 524287);
`else
    chk("wrap_i", 64'($signed(sig_out_i)), -248582);
`endif
    // alternating banks mid-stream
    wr(9, 0, 0);
    step();
    put(123456, 0, 524287, 0);
    for (int n = 0; n < 40; n++) begin
      if (n % 5 == 0) wr(0, (n % 10 == 0) ? 32768 : 65536, 1);
      step();
      if (n >= 4) begin
        chk("atom_i", {63'b0, ($signed(sig_out_i) == 123456 || $signed(sig_out_i) == 61728)}, 1);
        chk("atom_q", 64'($signed(sig_out_q)), 0);
      end
    end
    // random traffic, writes (including ignored addresses) and swaps
    for (int n = 0; n < 250; n++) begin
      sig_in_i = 20'($urandom);
      sig_in_q = 20'($urandom);
      foreach (mag[k]) mag[k] = 20'($urandom_range(0, 524287));
      in_valid = 1'($urandom);
      if ($urandom_range(0, 2) == 0) wr(int'($urandom_range(0, 15)), int'($urandom), 0);
      if ($urandom_range(0, 7) == 0) coef_swap = 1;
      step();
    end
    // reset during a valid stream with a modified bank
    put(77777, -33333, 524287, 100000);
    for (int k = 2; k < 5; k++) mag[k] = 20'($urandom_range(0, 524287));
    wr(0, 40000, 1);
    step();
    repeat (2) step();
    reset = 1;
    step();
    chk("rst_valid", {63'b0, out_valid}, 0);
    chk("rst_i", 64'($signed(sig_out_i)), 0);
    chk("rst_q", 64'($signed(sig_out_q)), 0);
    repeat (4) step();
    chk("rst_id_valid", {63'b0, out_valid}, 1);
    chk("rst_id_i", 64'($signed(sig_out_i)), 77777);
    chk("rst_id_q", 64'($signed(sig_out_q)), -33333);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
